area_point_gen: RTL and testbench



---
 rtl/area_point_gen_if.sv | 25 ++
 rtl/area_point_gen.sv | 188 ++++++++++++++++++
 tb/tb_area_point_gen.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/area_point_gen_if.sv
// Valid/ready coordinate stream carrying one (row, col, tier) point per beat.
// The generator drives it through the master modport; the consumer uses slave.
interface area_point_gen_if;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] out_row;
  logic [6:0] out_col;
  logic [1:0] out_tier;

  modport master (
    output out_valid,
    output out_row,
    output out_col,
    output out_tier,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_row,
    input  out_col,
    input  out_tier,
    output out_ready
  );
endinterface

// File: rtl/area_point_gen.sv
// Streams the 12-point highlight halo around a centre row ID, skipping rows off the panel.
// Optional macro TIER_MASK_EN adds a per-tier enable input latched with the ID.
module area_point_gen #(
  parameter int F_COL = 96,
  parameter int ROWS  = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [6:0]       id,
`ifdef TIER_MASK_EN
  input  logic [2:0]       tier_mask,
`endif
  area_point_gen_if.master bus,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_e;

  typedef struct packed {
    logic [6:0] row;
    logic [6:0] col;
    logic [1:0] tier;
  } point_t;

  localparam logic [3:0] LAST_IDX = 4'd11;
  localparam logic [7:0] ROWS_LIM = 8'(ROWS);
  localparam logic [6:0] COL_T1   = 7'(F_COL);
  localparam logic [6:0] COL_T2   = 7'(F_COL - 1);
  localparam logic [6:0] COL_T3   = 7'(F_COL - 2);

  state_e     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [6:0] id_q, id_d;
  logic       valid_q, valid_d;
  logic [6:0] row_q, row_d;
  logic [6:0] col_q, col_d;
  logic [1:0] tier_q, tier_d;
`ifdef TIER_MASK_EN
  logic [2:0] mask_q, mask_d;
`endif

  logic       advance;
  logic       lastIdx;
  logic       load;
  logic [3:0] evalIdx;
  logic [6:0] evalId;
  logic [2:0] evalMask;
  logic       tierOn;
  point_t     pt;

  // Fixed emission order; row arithmetic wraps modulo 128 so rows near 0 land high and get skipped.
  function automatic point_t pointOf(input logic [3:0] k, input logic [6:0] c);
    point_t p;
    p.row  = c;
    p.col  = COL_T1;
    p.tier = 2'd1;
    case (k)
      4'd0:  ;
      4'd1:  begin p.row = c - 7'd1; p.col = COL_T2; p.tier = 2'd2; end
      4'd2:  begin p.row = c + 7'd1; p.col = COL_T2; p.tier = 2'd2; end
      4'd3:  begin p.row = c - 7'd1; p.col = COL_T1; p.tier = 2'd2; end
      4'd4:  begin p.row = c + 7'd1; p.col = COL_T1; p.tier = 2'd2; end
      4'd5:  begin p.row = c - 7'd2; p.col = COL_T2; p.tier = 2'd3; end
      4'd6:  begin p.row = c + 7'd2; p.col = COL_T2; p.tier = 2'd3; end
      4'd7:  begin p.row = c - 7'd2; p.col = COL_T1; p.tier = 2'd3; end
      4'd8:  begin p.row = c + 7'd2; p.col = COL_T1; p.tier = 2'd3; end
      4'd9:  begin p.row = c - 7'd2; p.col = COL_T3; p.tier = 2'd3; end
      4'd10: begin p.row = c + 7'd2; p.col = COL_T3; p.tier = 2'd3; end
      4'd11: begin p.row = c;        p.col = COL_T3; p.tier = 2'd3; end
      default: ;
    endcase
    return p;
  endfunction

  // A skipped index (valid low) always advances; a presented one waits for ready.
  assign advance = valid_q ? bus.out_ready : 1'b1;
  assign lastIdx = (idx_q == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      id_q    <= '0;
      valid_q <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
      tier_q  <= '0;
`ifdef TIER_MASK_EN
      mask_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      id_q    <= id_d;
      valid_q <= valid_d;
      row_q   <= row_d;
      col_q   <= col_d;
      tier_q  <= tier_d;
`ifdef TIER_MASK_EN
      mask_q  <= mask_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (advance && lastIdx) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != IDLE);
    done    = (state_q == FIN);
    idx_d   = idx_q;
    id_d    = id_q;
    valid_d = valid_q;
    row_d   = row_q;
    col_d   = col_q;
    tier_d  = tier_q;
    load    = 1'b0;
    evalIdx = idx_q;
    evalId  = id_q;
`ifdef TIER_MASK_EN
    mask_d   = mask_q;
    evalMask = mask_q;
`else
    evalMask = 3'b111;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          idx_d   = '0;
          id_d    = id;
          evalIdx = '0;
          evalId  = id;
          load    = 1'b1;
`ifdef TIER_MASK_EN
          mask_d   = tier_mask;
          evalMask = tier_mask;
`endif
        end
      end
      RUN: begin
        if (advance) begin
          if (lastIdx) begin
            valid_d = 1'b0;
          end else begin
            idx_d   = idx_q + 4'd1;
            evalIdx = idx_q + 4'd1;
            load    = 1'b1;
          end
        end
      end
      FIN: begin
        valid_d = 1'b0;
        idx_d   = '0;
      end
      default: valid_d = 1'b0;
    endcase

    pt = pointOf(evalIdx, evalId);
    case (pt.tier)
      2'd1:    tierOn = evalMask[0];
      2'd2:    tierOn = evalMask[1];
      default: tierOn = evalMask[2];
    endcase

    if (load) begin
      valid_d = ({1'b0, pt.row} < ROWS_LIM) && tierOn;
      row_d   = pt.row;
      col_d   = pt.col;
      tier_d  = pt.tier;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_row   = row_q;
  assign bus.out_col   = col_q;
  assign bus.out_tier  = tier_q;

endmodule

// File: tb/tb_area_point_gen.sv
// Directed bench for area_point_gen: halo order, row skipping, back-pressure, reset abort, busy-ignore.
module tb_area_point_gen;
  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [6:0] id;
`ifdef TIER_MASK_EN
  logic [2:0] tier_mask;
`endif
  logic       busy;
  logic       done;

  area_point_gen_if bus();

  area_point_gen dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .id        (id),
`ifdef TIER_MASK_EN
    .tier_mask (tier_mask),
`endif
    .bus       (bus.master),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [15:0] beatQ[$];
  int          beatCycQ[$];
  int          doneCycle;
  int          doneCount;
  int          stallErr;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues a one-cycle start; afterwards we sit in the first cycle of the sequence.
  task automatic startSeq(input logic [6:0] cid, input logic [2:0] m);
    start = 1'b1;
    id    = cid;
`ifdef TIER_MASK_EN
    tier_mask = m;
`else
    if (m == 3'b000) id = cid;
`endif
    tick();
    start = 1'b0;
    id    = 7'h55;
  endtask

  // Records beats, done pulses and stall-hold violations; makes no judgement itself.
  task automatic collect(input int maxCyc, input logic [7:0] pat, input int patLen, input int stCyc);
    logic        pv;
    logic [15:0] pp;
    logic [15:0] cur;
    int          after;
    beatQ.delete();
    beatCycQ.delete();
    doneCycle = -1;
    doneCount = 0;
    stallErr  = 0;
    pv        = 1'b0;
    pp        = '0;
    after     = 0;
    for (int c = 1; c <= maxCyc; c++) begin
      bus.out_ready = pat[(c - 1) % patLen];
      start = (c == stCyc);
      if (c == stCyc) id = 7'd30;
      cur = {bus.out_row, bus.out_col, bus.out_tier};
      if (pv && (bus.out_valid !== 1'b1 || cur !== pp)) stallErr++;
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        beatQ.push_back(cur);
        beatCycQ.push_back(c);
      end
      if (done === 1'b1) begin
        doneCount++;
        if (doneCycle < 0) doneCycle = c;
      end
      pv = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b0);
      pp = cur;
      tick();
      if (doneCycle >= 0) begin
        after++;
        if (after > 3) break;
      end
    end
    start = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.out_row !== 7'd0) begin failures++; $display("[TB] FAIL reset_row got=%0d exp=0", bus.out_row); end
    checks++; if (bus.out_col !== 7'd0) begin failures++; $display("[TB] FAIL reset_col got=%0d exp=0", bus.out_col); end
    checks++; if (bus.out_tier !== 2'd0) begin failures++; $display("[TB] FAIL reset_tier got=%0d exp=0", bus.out_tier); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b exp=0", done); end
    rst = 1'b0;
    tick();
    checks++; if (busy !== 1'b0 || bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL idle_after_reset busy=%b valid=%b exp=0/0", busy, bus.out_valid); end
  endtask

  task automatic test_nominal();
    logic [15:0] exp [12];
    logic [15:0] got;
    exp = '{{7'd10,7'd96,2'd1},
            {7'd9,7'd95,2'd2}, {7'd11,7'd95,2'd2}, {7'd9,7'd96,2'd2}, {7'd11,7'd96,2'd2},
            {7'd8,7'd95,2'd3}, {7'd12,7'd95,2'd3}, {7'd8,7'd96,2'd3}, {7'd12,7'd96,2'd3},
            {7'd8,7'd94,2'd3}, {7'd12,7'd94,2'd3}, {7'd10,7'd94,2'd3}};
    startSeq(7'd10, 3'b111);
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL nominal_busy got=%b exp=1", busy); end
    collect(40, 8'hFF, 1, 0);
    checks++; if (beatQ.size() != 12) begin failures++; $display("[TB] FAIL nominal_count got=%0d exp=12", beatQ.size()); end
    for (int i = 0; i < 12; i++) begin
      got = (i < beatQ.size()) ? beatQ[i] : 16'hFFFF;
      checks++; if (got !== exp[i]) begin failures++; $display("[TB] FAIL nominal_beat%0d got=%h exp=%h", i, got, exp[i]); end
      checks++; if (i < beatCycQ.size() && beatCycQ[i] != i + 1) begin failures++; $display("[TB] FAIL nominal_cycle%0d got=%0d exp=%0d", i, beatCycQ[i], i + 1); end
    end
    checks++; if (doneCycle != 13) begin failures++; $display("[TB] FAIL nominal_done_cycle got=%0d exp=13", doneCycle); end
    checks++; if (doneCount != 1) begin failures++; $display("[TB] FAIL nominal_done_count got=%0d exp=1", doneCount); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL nominal_busy_end got=%b exp=0", busy); end
  endtask

  task automatic test_row_skip();
    logic [15:0] expLo [9];
    logic [15:0] expHi [7];
    logic [15:0] got;
    expLo = '{{7'd1,7'd96,2'd1},
              {7'd0,7'd95,2'd2}, {7'd2,7'd95,2'd2}, {7'd0,7'd96,2'd2}, {7'd2,7'd96,2'd2},
              {7'd3,7'd95,2'd3}, {7'd3,7'd96,2'd3}, {7'd3,7'd94,2'd3}, {7'd1,7'd94,2'd3}};
    expHi = '{{7'd63,7'd96,2'd1}, {7'd62,7'd95,2'd2}, {7'd62,7'd96,2'd2},
              {7'd61,7'd95,2'd3}, {7'd61,7'd96,2'd3}, {7'd61,7'd94,2'd3}, {7'd63,7'd94,2'd3}};
    startSeq(7'd1, 3'b111);
    collect(40, 8'hFF, 1, 0);
    checks++; if (beatQ.size() != 9) begin failures++; $display("[TB] FAIL low_count got=%0d exp=9", beatQ.size()); end
    for (int i = 0; i < 9; i++) begin
      got = (i < beatQ.size()) ? beatQ[i] : 16'hFFFF;
      checks++; if (got !== expLo[i]) begin failures++; $display("[TB] FAIL low_beat%0d got=%h exp=%h", i, got, expLo[i]); end
    end
    checks++; if (doneCycle != 13) begin failures++; $display("[TB] FAIL low_done_cycle got=%0d exp=13", doneCycle); end
    startSeq(7'd63, 3'b111);
    collect(40, 8'hFF, 1, 0);
    checks++; if (beatQ.size() != 7) begin failures++; $display("[TB] FAIL high_count got=%0d exp=7", beatQ.size()); end
    for (int i = 0; i < 7; i++) begin
      got = (i < beatQ.size()) ? beatQ[i] : 16'hFFFF;
      checks++; if (got !== expHi[i]) begin failures++; $display("[TB] FAIL high_beat%0d got=%h exp=%h", i, got, expHi[i]); end
    end
    checks++; if (doneCycle != 13) begin failures++; $display("[TB] FAIL high_done_cycle got=%0d exp=13", doneCycle); end
  endtask

  task automatic test_backpressure();
    logic [15:0] exp [12];
    logic [15:0] got;
    exp = '{{7'd20,7'd96,2'd1},
            {7'd19,7'd95,2'd2}, {7'd21,7'd95,2'd2}, {7'd19,7'd96,2'd2}, {7'd21,7'd96,2'd2},
            {7'd18,7'd95,2'd3}, {7'd22,7'd95,2'd3}, {7'd18,7'd96,2'd3}, {7'd22,7'd96,2'd3},
            {7'd18,7'd94,2'd3}, {7'd22,7'd94,2'd3}, {7'd20,7'd94,2'd3}};
    startSeq(7'd20, 3'b111);
    collect(80, 8'b0000_1001, 4, 0);
    checks++; if (beatQ.size() != 12) begin failures++; $display("[TB] FAIL bp_count got=%0d exp=12", beatQ.size()); end
    for (int i = 0; i < 12; i++) begin
      got = (i < beatQ.size()) ? beatQ[i] : 16'hFFFF;
      checks++; if (got !== exp[i]) begin failures++; $display("[TB] FAIL bp_beat%0d got=%h exp=%h", i, got, exp[i]); end
    end
    checks++; if (stallErr != 0) begin failures++; $display("[TB] FAIL bp_stall_hold got=%0d exp=0", stallErr); end
    checks++; if (doneCount != 1) begin failures++; $display("[TB] FAIL bp_done_count got=%0d exp=1", doneCount); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] exp [12];
    logic [15:0] got;
    int          dn;
    exp = '{{7'd5,7'd96,2'd1},
            {7'd4,7'd95,2'd2}, {7'd6,7'd95,2'd2}, {7'd4,7'd96,2'd2}, {7'd6,7'd96,2'd2},
            {7'd3,7'd95,2'd3}, {7'd7,7'd95,2'd3}, {7'd3,7'd96,2'd3}, {7'd7,7'd96,2'd3},
            {7'd3,7'd94,2'd3}, {7'd7,7'd94,2'd3}, {7'd5,7'd94,2'd3}};
    bus.out_ready = 1'b1;
    startSeq(7'd5, 3'b111);
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL midrst_valid got=%b exp=0", bus.out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL midrst_busy got=%b exp=0", busy); end
    checks++; if (bus.out_row !== 7'd0 || bus.out_col !== 7'd0) begin failures++; $display("[TB] FAIL midrst_point got=%0d/%0d exp=0/0", bus.out_row, bus.out_col); end
    dn = (done === 1'b1) ? 1 : 0;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done === 1'b1) dn++;
    end
    checks++; if (dn != 0) begin failures++; $display("[TB] FAIL midrst_no_done got=%0d exp=0", dn); end
    startSeq(7'd5, 3'b111);
    collect(40, 8'hFF, 1, 0);
    checks++; if (beatQ.size() != 12) begin failures++; $display("[TB] FAIL restart_count got=%0d exp=12", beatQ.size()); end
    for (int i = 0; i < 12; i++) begin
      got = (i < beatQ.size()) ? beatQ[i] : 16'hFFFF;
      checks++; if (got !== exp[i]) begin failures++; $display("[TB] FAIL restart_beat%0d got=%h exp=%h", i, got, exp[i]); end
    end
    checks++; if (doneCycle != 13) begin failures++; $display("[TB] FAIL restart_done_cycle got=%0d exp=13", doneCycle); end
  endtask

  task automatic test_busy_ignore();
    logic [15:0] exp [12];
    logic [15:0] got;
    exp = '{{7'd10,7'd96,2'd1},
            {7'd9,7'd95,2'd2}, {7'd11,7'd95,2'd2}, {7'd9,7'd96,2'd2}, {7'd11,7'd96,2'd2},
            {7'd8,7'd95,2'd3}, {7'd12,7'd95,2'd3}, {7'd8,7'd96,2'd3}, {7'd12,7'd96,2'd3},
            {7'd8,7'd94,2'd3}, {7'd12,7'd94,2'd3}, {7'd10,7'd94,2'd3}};
    startSeq(7'd10, 3'b111);
    collect(40, 8'hFF, 1, 3);
    checks++; if (beatQ.size() != 12) begin failures++; $display("[TB] FAIL ignore_count got=%0d exp=12", beatQ.size()); end
    for (int i = 0; i < 12; i++) begin
      got = (i < beatQ.size()) ? beatQ[i] : 16'hFFFF;
      checks++; if (got !== exp[i]) begin failures++; $display("[TB] FAIL ignore_beat%0d got=%h exp=%h", i, got, exp[i]); end
    end
    checks++; if (doneCycle != 13) begin failures++; $display("[TB] FAIL ignore_done_cycle got=%0d exp=13", doneCycle); end
    checks++; if (doneCount != 1) begin failures++; $display("[TB] FAIL ignore_done_count got=%0d exp=1", doneCount); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL ignore_busy_end got=%b exp=0", busy); end
  endtask

`ifdef TIER_MASK_EN
  task automatic test_tier_mask();
    logic [15:0] exp [4];
    logic [15:0] got;
    exp = '{{7'd9,7'd95,2'd2}, {7'd11,7'd95,2'd2}, {7'd9,7'd96,2'd2}, {7'd11,7'd96,2'd2}};
    startSeq(7'd10, 3'b010);
    collect(40, 8'hFF, 1, 0);
    checks++; if (beatQ.size() != 4) begin failures++; $display("[TB] FAIL mask_count got=%0d exp=4", beatQ.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (i < beatQ.size()) ? beatQ[i] : 16'hFFFF;
      checks++; if (got !== exp[i]) begin failures++; $display("[TB] FAIL mask_beat%0d got=%h exp=%h", i, got, exp[i]); end
      checks++; if (i < beatCycQ.size() && beatCycQ[i] != i + 2) begin failures++; $display("[TB] FAIL mask_cycle%0d got=%0d exp=%0d", i, beatCycQ[i], i + 2); end
    end
    checks++; if (doneCycle != 13) begin failures++; $display("[TB] FAIL mask_done_cycle got=%0d exp=13", doneCycle); end
    startSeq(7'd10, 3'b000);
    collect(40, 8'hFF, 1, 0);
    checks++; if (beatQ.size() != 0) begin failures++; $display("[TB] FAIL mask0_count got=%0d exp=0", beatQ.size()); end
    checks++; if (doneCycle != 13) begin failures++; $display("[TB] FAIL mask0_done_cycle got=%0d exp=13", doneCycle); end
  endtask
`endif

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    id    = 7'd0;
`ifdef TIER_MASK_EN
    tier_mask = 3'b111;
`endif
    bus.out_ready = 1'b1;
    test_reset();
    test_nominal();
    test_row_skip();
    test_backpressure();
    test_reset_mid();
    test_busy_ignore();
`ifdef TIER_MASK_EN
    test_tier_mask();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
